// File: rtl/pll_drp_pkg.sv
// Shared types, FSM state codes and per-profile DRP register tables for the PLL reconfiguration controller.
// Each entry is a masked read-modify-write: mask bit 1 keeps the bit that was read back.
package pll_drp_pkg;

    localparam int TBL_ENTRIES = 8;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_RST       = 4'd1;
    localparam logic [3:0] ST_RD        = 4'd2;
    localparam logic [3:0] ST_RD_WAIT   = 4'd3;
    localparam logic [3:0] ST_WR        = 4'd4;
    localparam logic [3:0] ST_WR_WAIT   = 4'd5;
    localparam logic [3:0] ST_RELEASE   = 4'd6;
    localparam logic [3:0] ST_LOCK_WAIT = 4'd7;
    localparam logic [3:0] ST_ERR       = 4'd8;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] data;
    } drp_entry_t;

    localparam drp_entry_t PROFILE_TBL [4][TBL_ENTRIES] = '{
        '{'{7'h08, 16'hF000, 16'h0104}, '{7'h09, 16'hF000, 16'h0104},
          '{7'h0A, 16'hF000, 16'h0104}, '{7'h0B, 16'hF000, 16'h0104},
          '{7'h0C, 16'hF000, 16'h0104}, '{7'h0D, 16'hF000, 16'h0104},
          '{7'h0E, 16'hF000, 16'h0104}, '{7'h0F, 16'hF000, 16'h0104}},
        '{'{7'h28, 16'h00FF, 16'h0100}, '{7'h29, 16'h00FF, 16'h0200},
          '{7'h2A, 16'h00FF, 16'h0300}, '{7'h2B, 16'h00FF, 16'h0400},
          '{7'h2C, 16'h00FF, 16'h0500}, '{7'h2D, 16'h00FF, 16'h0600},
          '{7'h2E, 16'h00FF, 16'h0700}, '{7'h2F, 16'h00FF, 16'h0800}},
        '{'{7'h14, 16'h1000, 16'h0083}, '{7'h15, 16'h8000, 16'h0041},
          '{7'h16, 16'hC000, 16'h1041}, '{7'h4E, 16'h66FF, 16'h0800},
          '{7'h4F, 16'h666F, 16'h1000}, '{7'h18, 16'hFC00, 16'h00FA},
          '{7'h19, 16'h8000, 16'h7C01}, '{7'h1A, 16'h8000, 16'h7DE9}},
        '{'{7'h14, 16'h1000, 16'h0145}, '{7'h15, 16'h8000, 16'h0000},
          '{7'h16, 16'hC000, 16'h1145}, '{7'h4E, 16'h66FF, 16'h9900},
          '{7'h4F, 16'h666F, 16'h9000}, '{7'h18, 16'hFC00, 16'h01F4},
          '{7'h19, 16'h8000, 16'h7C01}, '{7'h1A, 16'h8000, 16'h7DE9}}
    };

endpackage

// File: rtl/pll_drp_rom.sv
// Combinational profile lookup: (sel, index) -> DRP address, keep-mask and write data.
// Indices past the stored table return an all-zero entry.
module pll_drp_rom
    import pll_drp_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic [1:0]       sel_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [6:0]       addr_o,
    output logic [15:0]      mask_o,
    output logic [15:0]      data_o
);

    logic [2:0] tbl_idx;
    drp_entry_t ent;

    assign tbl_idx = 3'(idx_i);

    always_comb begin
        ent = '0;
        if (32'(idx_i) < TBL_ENTRIES) begin
            ent = PROFILE_TBL[sel_i][tbl_idx];
        end
    end

    assign addr_o = ent.addr;
    assign mask_o = ent.mask;
    assign data_o = ent.data;

endmodule

// File: rtl/pll_drp_ctrl.sv
// Holds the PLL in reset, read-modify-writes one DRP profile entry by entry, then releases and waits for lock.
// One DRP transaction outstanding at a time; DRDY and lock waits are bounded by timeouts that end in ERR.
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int NUM_ENTRIES  = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 20000,
    parameter int LOCK_BLANK   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_req_i,
    input  logic [1:0]  cfg_sel_i,
    output logic        cfg_busy_o,
    output logic        cfg_done_o,
    output logic        cfg_err_o,
    output logic [6:0]  drp_addr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    input  logic        drp_drdy_i,
    output logic        pll_rst_o,
    input  logic        pll_locked_i
);

    localparam int IDX_W   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CNT_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    logic [3:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       addr_q, addr_d;
    logic [15:0]      di_q, di_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             idx_last;
    logic [6:0]       ent_addr;
    logic [15:0]      ent_mask, ent_data;

    assign idx_last = (idx_q == IDX_W'(NUM_ENTRIES - 1));

    // The ROM is addressed with the next index so address/data registers load on the transition into RD/WR.
    always_comb begin
        sel_d = sel_q;
        idx_d = idx_q;
        if (state_q == ST_IDLE && cfg_req_i) begin
            sel_d = cfg_sel_i;
            idx_d = '0;
        end else if (state_q == ST_WR_WAIT && drp_drdy_i && !idx_last) begin
            idx_d = idx_q + 1'b1;
        end
    end

    pll_drp_rom #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_rom (
        .sel_i  (sel_d),
        .idx_i  (idx_d),
        .addr_o (ent_addr),
        .mask_o (ent_mask),
        .data_o (ent_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        addr_d  = addr_q;
        di_d    = di_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cfg_req_i) begin
                    err_d   = 1'b0;
                    state_d = ST_RST;
                end
            end
            ST_RST: begin
                addr_d  = ent_addr;
                state_d = ST_RD;
            end
            ST_RD: begin
                cnt_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (drp_drdy_i) begin
                    di_d    = (drp_do_i & ent_mask) | ent_data;
                    state_d = ST_WR;
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_WR: begin
                cnt_d   = '0;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (drp_drdy_i) begin
                    if (idx_last) begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        addr_d  = ent_addr;
                        state_d = ST_RD;
                    end
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            // Counter keeps running from RELEASE entry so the lock timeout covers the blanking window too.
            ST_RELEASE: begin
                if (cnt_q == CNT_W'(LOCK_BLANK - 1)) begin
                    state_d = ST_LOCK_WAIT;
                end
            end
            ST_LOCK_WAIT: begin
                if (pll_locked_i) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            di_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign cfg_busy_o = (state_q != ST_IDLE);
    assign cfg_done_o = done_q;
    assign cfg_err_o  = err_q;
    assign drp_addr_o = addr_q;
    assign drp_di_o   = di_q;
    assign drp_den_o  = (state_q == ST_RD) || (state_q == ST_WR);
    assign drp_dwe_o  = (state_q == ST_WR);
    assign pll_rst_o  = (state_q == ST_RST) || (state_q == ST_RD) || (state_q == ST_RD_WAIT) ||
                        (state_q == ST_WR)  || (state_q == ST_WR_WAIT);

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Scoreboard bench: stimulus pushes expected DRP/done/error events, a negedge monitor pops and compares them.
// DRP and PLL lock behaviour come from small behavioural models driven alongside the stimulus.
module tb_pll_drp_ctrl;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        logic [6:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_req_i = 1'b0;
    logic [1:0]  cfg_sel_i = 2'd0;
    logic        cfg_busy_o, cfg_done_o, cfg_err_o;
    logic [6:0]  drp_addr_o;
    logic [15:0] drp_di_o;
    logic [15:0] drp_do_i = 16'h0000;
    logic        drp_den_o, drp_dwe_o;
    logic        drp_drdy_i = 1'b0;
    logic        pll_rst_o;
    logic        pll_locked_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    ev_t exp_q[$];

    int          drp_lat = 3;
    logic        drp_silent = 1'b0;
    logic [15:0] rd_val = 16'hFFFF;
    int          lock_mode = 0;   // 0: lock after lock_dly, 1: never, 2: stuck high
    int          lock_dly = 20;

    logic [15:0] p1_wr [8] = '{16'h01A5, 16'h02A5, 16'h03A5, 16'h04A5,
                               16'h05A5, 16'h06A5, 16'h07A5, 16'h08A5};

    pll_drp_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cfg_req_i    (cfg_req_i),
        .cfg_sel_i    (cfg_sel_i),
        .cfg_busy_o   (cfg_busy_o),
        .cfg_done_o   (cfg_done_o),
        .cfg_err_o    (cfg_err_o),
        .drp_addr_o   (drp_addr_o),
        .drp_di_o     (drp_di_o),
        .drp_do_i     (drp_do_i),
        .drp_den_o    (drp_den_o),
        .drp_dwe_o    (drp_dwe_o),
        .drp_drdy_i   (drp_drdy_i),
        .pll_rst_o    (pll_rst_o),
        .pll_locked_i (pll_locked_i)
    );

    initial forever #5 clk_i = ~clk_i;
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // DRP slave: DRDY for one cycle, drp_lat cycles after the DEN cycle.
    initial begin
        int pend;
        pend = 0;
        forever begin
            @(posedge clk_i);
            #1;
            drp_drdy_i = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drp_drdy_i = 1'b1;
                    drp_do_i   = rd_val;
                end
            end
            if (drp_den_o && !drp_silent) pend = drp_lat;
        end
    end

    initial begin
        int rel;
        rel = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (pll_rst_o) rel = 0;
            else rel++;
            case (lock_mode)
                1:       pll_locked_i = 1'b0;
                2:       pll_locked_i = 1'b1;
                default: pll_locked_i = !pll_rst_o && (rel >= lock_dly);
            endcase
        end
    end

    task automatic check_evt(input int kind, input logic [6:0] addr, input logic [15:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind=%0d addr=0x%0h data=0x%0h, expected no event", kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind ||
                ((kind == K_RD || kind == K_WR) && e.addr != addr) ||
                (kind == K_WR && e.data != data)) begin
                errors++;
                $display("FAIL sb_event: got kind=%0d addr=0x%0h data=0x%0h, expected kind=%0d addr=0x%0h data=0x%0h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    initial begin
        logic prev_err;
        prev_err = 1'b0;
        forever begin
            @(negedge clk_i);
            if (drp_den_o) check_evt(drp_dwe_o ? K_WR : K_RD, drp_addr_o, drp_di_o);
            if (cfg_done_o) check_evt(K_DONE, 7'h0, 16'h0);
            if (cfg_err_o && !prev_err) check_evt(K_ERR, 7'h0, 16'h0);
            prev_err = cfg_err_o;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [6:0] addr, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Profile 0 read back as 0xFFFF writes 0xF104; profile 1 read back as 0xA5A5 writes p1_wr.
    task automatic push_seq(input int prof, input int n);
        for (int i = 0; i < n; i++) begin
            logic [6:0] a;
            a = (prof == 0) ? 7'(8'h08 + i) : 7'(8'h28 + i);
            push_ev(K_RD, a, 16'h0);
            push_ev(K_WR, a, (prof == 0) ? 16'hF104 : p1_wr[i]);
        end
    endtask

    function automatic logic sig(input int k);
        case (k)
            0:       sig = !pll_rst_o;
            1:       sig = cfg_done_o;
            2:       sig = cfg_err_o;
            3:       sig = drp_dwe_o;
            default: sig = drp_den_o;
        endcase
    endfunction

    task automatic wait_for(input int k, input int bound, input string nm, output int at);
        int n;
        n = 0;
        at = -1;
        while (at < 0 && n < bound) begin
            @(negedge clk_i);
            if (sig(k)) at = cyc;
            n++;
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL %s: no event within %0d cycles", nm, bound);
        end
    endtask

    task automatic start_req(input logic [1:0] sel, input string nm);
        @(negedge clk_i);
        cfg_sel_i = sel;
        cfg_req_i = 1'b1;
        @(negedge clk_i);
        cfg_req_i = 1'b0;
        chk({nm, "_busy"}, 32'(cfg_busy_o), 32'd1);
        chk({nm, "_pll_rst"}, 32'(pll_rst_o), 32'd1);
        chk({nm, "_err_clr"}, 32'(cfg_err_o), 32'd0);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_busy"}, 32'(cfg_busy_o), 32'd0);
        chk({nm, "_done"}, 32'(cfg_done_o), 32'd0);
        chk({nm, "_err"}, 32'(cfg_err_o), 32'd0);
        chk({nm, "_addr"}, 32'(drp_addr_o), 32'd0);
        chk({nm, "_di"}, 32'(drp_di_o), 32'd0);
        chk({nm, "_den"}, 32'(drp_den_o), 32'd0);
        chk({nm, "_dwe"}, 32'(drp_dwe_o), 32'd0);
        chk({nm, "_pll_rst"}, 32'(pll_rst_o), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, d, t0, te, dummy;
        repeat (3) @(negedge clk_i);
        chk_outputs_zero("reset");
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);

        // Profile 0, 3-cycle DRDY, lock 20 cycles after release
        push_seq(0, 8);
        push_ev(K_DONE, 7'h0, 16'h0);
        start_req(2'd0, "p0");
        wait_for(0, 300, "p0_release", r);
        wait_for(1, 100, "p0_done", d);
        chk("p0_lock_latency", 32'(d - r), 32'd20);
        wait_drain("p0");

        // DRDY never returned on the first read
        drp_silent = 1'b1;
        push_ev(K_RD, 7'h08, 16'h0);
        push_ev(K_ERR, 7'h0, 16'h0);
        start_req(2'd0, "drdy_to");
        wait_for(4, 10, "drdy_to_den", t0);
        wait_for(2, 200, "drdy_to_err", te);
        chk("drdy_to_latency", 32'(te - t0), 32'd65);
        chk("drdy_to_pll_rst", 32'(pll_rst_o), 32'd0);
        repeat (20) @(negedge clk_i);
        chk("drdy_to_idle", 32'(cfg_busy_o), 32'd0);
        chk("drdy_to_sticky", 32'(cfg_err_o), 32'd1);
        wait_drain("drdy_to");
        drp_silent = 1'b0;

        // Lock never asserted
        lock_mode = 1;
        push_seq(0, 8);
        push_ev(K_ERR, 7'h0, 16'h0);
        start_req(2'd0, "lock_to");
        wait_for(0, 300, "lock_to_release", r);
        wait_for(2, 20100, "lock_to_err", te);
        chk("lock_to_latency", 32'(te - r), 32'd20000);
        wait_drain("lock_to");

        // Profile 1, different readback, early lock hidden by blanking
        lock_mode = 0;
        lock_dly = 5;
        rd_val = 16'hA5A5;
        push_seq(1, 8);
        push_ev(K_DONE, 7'h0, 16'h0);
        start_req(2'd1, "p1");
        wait_for(0, 300, "p1_release", r);
        wait_for(1, 100, "p1_done", d);
        chk("p1_lock_latency", 32'(d - r), 32'd9);
        wait_drain("p1");

        // Lock stuck high
        lock_mode = 2;
        rd_val = 16'hFFFF;
        push_seq(0, 8);
        push_ev(K_DONE, 7'h0, 16'h0);
        start_req(2'd0, "stuck");
        wait_for(0, 300, "stuck_release", r);
        wait_for(1, 100, "stuck_done", d);
        chk("stuck_lock_latency", 32'(d - r), 32'd9);
        wait_drain("stuck");

        // Request pulsed during WR_WAIT must not start a second sequence
        lock_mode = 0;
        lock_dly = 20;
        push_seq(0, 8);
        push_ev(K_DONE, 7'h0, 16'h0);
        start_req(2'd0, "req_ign");
        wait_for(3, 50, "req_ign_wr", dummy);
        @(negedge clk_i);
        cfg_sel_i = 2'd2;
        cfg_req_i = 1'b1;
        @(negedge clk_i);
        cfg_req_i = 1'b0;
        wait_for(1, 400, "req_ign_done", d);
        repeat (40) @(negedge clk_i);
        chk("req_ign_idle", 32'(cfg_busy_o), 32'd0);
        wait_drain("req_ign");

        // Reset during the entry-4 write
        push_seq(0, 5);
        start_req(2'd0, "mid_rst");
        for (int i = 0; i < 5; i++) wait_for(3, 50, "mid_rst_wr", dummy);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk_outputs_zero("mid_rst");
        rst_ni = 1'b1;
        repeat (100) @(negedge clk_i);
        chk("mid_rst_idle", 32'(cfg_busy_o), 32'd0);
        wait_drain("mid_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_drp_ctrl.md
PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

Interface
REQ-001 Parameter: NUM_ENTRIES, default 8, number of DRP register entries per configuration profile.
REQ-002 Parameter: DRDY_TIMEOUT, default 64, max cycles from DEN pulse to DRDY.
REQ-003 Parameter: LOCK_TIMEOUT, default 20000, max cycles from PLL reset release to stable lock (200 us at 100 MHz).
REQ-004 Parameter: LOCK_BLANK, default 8, cycles after PLL reset release during which pll_locked_i is ignored.
REQ-005 clk_i  input  1  single block clock (clk_100 domain).
REQ-006 rst_ni  input  1  reset; synchronous, active-low.
REQ-007 cfg_req_i  input  1  start a reconfiguration; level, sampled only in IDLE.
REQ-008 cfg_sel_i  input  2  profile index 0..3; latched when cfg_req_i is accepted.
REQ-009 cfg_busy_o  output  1  high from acceptance until return to IDLE.
REQ-010 cfg_done_o  output  1  one-cycle pulse on successful completion.
REQ-011 cfg_err_o  output  1  sticky timeout flag; cleared when the next request is accepted.
REQ-012 drp_addr_o  output  7  DRP address; drp_di_o  output  16  DRP write data; drp_do_i  input  16  DRP read data.
REQ-013 drp_den_o  output  1  DRP enable; drp_dwe_o  output  1  DRP write enable; drp_drdy_i  input  1  DRP ready.
REQ-014 pll_rst_o  output  1  PLL RST drive; pll_locked_i  input  1  PLL LOCKED (pre-synchronised to clk_i by the instantiating level).

Function
REQ-015 States: IDLE, RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT, ERR.
REQ-016 IDLE with cfg_req_i=1: latch cfg_sel_i, clear cfg_err_o, entry index=0, go to RST; cfg_busy_o and pll_rst_o high from the next cycle.
REQ-017 cfg_req_i is ignored in every state other than IDLE; no queuing.
REQ-018 RST lasts one cycle, then RD; pll_rst_o stays high through RD..WR_WAIT.
REQ-019 RD: drp_den_o=1, drp_dwe_o=0 for exactly one cycle, drp_addr_o=entry addr; then RD_WAIT.
REQ-020 RD_WAIT: on drp_drdy_i=1 capture drp_do_i and go to WR.
REQ-021 WR: drp_den_o=1, drp_dwe_o=1 for exactly one cycle; drp_di_o = (captured & entry mask) | entry data (mask bit 1 = keep); then WR_WAIT.
REQ-022 WR_WAIT: on drp_drdy_i=1, if index=NUM_ENTRIES-1 go to RELEASE, else increment index and go to RD.
REQ-023 drp_den_o never asserted while a DRP transaction is outstanding; drp_drdy_i outside RD_WAIT/WR_WAIT is ignored.
REQ-024 DRDY timeout: RD_WAIT or WR_WAIT exceeding DRDY_TIMEOUT cycles -> ERR.
REQ-025 RELEASE: pll_rst_o=0; wait LOCK_BLANK cycles, then LOCK_WAIT.
REQ-026 LOCK_WAIT: pll_locked_i=1 -> cfg_done_o pulse, go to IDLE; total cycles since RELEASE entry exceeding LOCK_TIMEOUT -> ERR.
REQ-027 ERR (one cycle): cfg_err_o=1, pll_rst_o=0, drp_den_o=0, go to IDLE; cfg_done_o not pulsed.
REQ-028 drp_addr_o/drp_di_o hold last values when drp_den_o=0; drp_dwe_o=0 whenever drp_den_o=0.
REQ-029 Timeout counters sized by $clog2 of the larger timeout plus one; no wrap before timeout fires.

Reset
REQ-030 rst_ni=0 at a clk_i edge: state=IDLE, all outputs 0 (incl. pll_rst_o, cfg_err_o), counters and index 0, from the next cycle.
REQ-031 Reset mid-operation aborts the sequence immediately; no DRP write completes after reset; PLL is released (pll_rst_o=0).

Structure
REQ-032 Package pll_drp_pkg holds state enum, entry struct {addr[6:0], mask[15:0], data[15:0]}, and 4 x NUM_ENTRIES profile constant table.
REQ-033 Sub-module pll_drp_rom: combinational lookup (sel, index) -> entry from the package table.

Verification
REQ-034 Profile 0, DRP model returns 0xFFFF with 3-cycle DRDY, entry mask 0xF000 data 0x0104 -> written value 0xF104; 8 reads + 8 writes; cfg_done_o one pulse.
REQ-035 DRP model never asserts DRDY on first read -> ERR after 64 cycles, cfg_err_o=1, pll_rst_o=0, no DEN thereafter.
REQ-036 pll_locked_i held low after release -> cfg_err_o at cycle 20000 after RELEASE; next cfg_req_i clears it.
REQ-037 pll_locked_i stuck high from release -> ignored for 8 cycles; done no earlier than cycle 9 after RELEASE.
REQ-038 cfg_req_i pulsed during WR_WAIT -> ignored; exactly one sequence and one done pulse.
REQ-039 rst_ni low during entry 4 write -> next cycle all outputs 0, state IDLE, no further DEN.
